// File: rtl/pc_branch_unit_if.sv
// Fetch-side bundle for pc_branch_unit: control, jump fields and ALU flags in,
// fetch address and status out.
interface pc_branch_unit_if #(
    parameter int unsigned PC_WIDTH = 4
);
    logic                run_en_dummy_unused;
    logic                en;
    logic                jmp_en;
    logic [2:0]          jmp_cond;
    logic [PC_WIDTH-1:0] jmp_addr;
    logic                flags_we;
    logic                alu_z;
    logic                alu_n;
    logic                alu_c;
    logic [PC_WIDTH-1:0] pc_out;
    logic [2:0]          flags_out;
    logic                taken;
    logic                halted;

    modport master (
        output en, jmp_en, jmp_cond, jmp_addr, flags_we, alu_z, alu_n, alu_c,
        input  pc_out, flags_out, taken, halted
    );

    modport slave (
        input  en, jmp_en, jmp_cond, jmp_addr, flags_we, alu_z, alu_n, alu_c,
        output pc_out, flags_out, taken, halted
    );
endinterface

// File: rtl/pc_branch_unit.sv
// Program counter with registered ALU flags, conditional jump resolution and
// an optional HALT state after the last instruction address.
module pc_branch_unit #(
    parameter int unsigned PC_WIDTH    = 4,
    parameter bit          HALT_AT_END = 1'b1
) (
    input logic             clk,
    input logic             rst,
    pc_branch_unit_if.slave bus
);
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [2:0]          flags_q, flags_d;
    logic                flag_z, flag_n, flag_c;
    logic                cond_true;
    logic                take;
    logic                pc_last;

    assign {flag_z, flag_n, flag_c} = flags_q;
    assign pc_last                  = (pc_q == '1);

    // Conditions look only at the registered flags, never this cycle's ALU result.
    always_comb begin
        cond_true = 1'b0;
        case (bus.jmp_cond)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = flag_z;
            3'b010:  cond_true = ~flag_z;
            3'b011:  cond_true = ~flag_n & ~flag_z;
            3'b100:  cond_true = ~flag_n;
            3'b101:  cond_true = flag_n;
            3'b110:  cond_true = flag_n | flag_z;
            3'b111:  cond_true = flag_c;
            default: cond_true = 1'b0;
        endcase
    end

    assign take = bus.en & bus.jmp_en & cond_true & (state_q == ST_RUN);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flags_d = flags_q;
        if (state_q == ST_RUN && bus.en) begin
            if (take) begin
                pc_d = bus.jmp_addr;
            end else if (pc_last && HALT_AT_END) begin
                state_d = ST_HALT;
            end else begin
                pc_d = pc_q + PC_WIDTH'(1);
            end
            if (bus.flags_we) begin
                flags_d = {bus.alu_z, bus.alu_n, bus.alu_c};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
        end
    end

    assign bus.pc_out    = pc_q;
    assign bus.flags_out = flags_q;
    assign bus.taken     = take;
    assign bus.halted    = (state_q == ST_HALT);
endmodule
